// File: rtl/fifo_sched_pkg.sv
// Shared types and defaults for the FIFO port scheduler.
// Holds the state/side enums and default FIFO geometry.
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD
  } state_t;

  typedef enum logic {
    WRITE,
    READ
  } side_t;

  localparam int DEPTH_DEF = 16;
  localparam int DW_DEF    = 8;

endpackage

// File: rtl/fifo_port_sched_rr_arbiter.sv
// Round-robin picker: first eligible index after ptr wins.
// Ports: elig (request vector), ptr (last owner), gnt (one-hot), idx (winner).
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         elig,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int PW = $clog2(N);

  // Walk from farthest to nearest so the nearest eligible
  // index after ptr is the one left standing.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      automatic int j = (int'(ptr) + k) % N;
      if (elig[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_port_sched.sv
// Shares one FIFO port among N_WR writers and one reader:
// round-robin writers, bounded bursts, read/write alternation.
// Ports: wr_req/wr_data/wr_gnt, rd_req/rd_gnt/rd_valid/rd_data,
// fifo_wr/fifo_rd/fifo_din/fifo_full/fifo_empty/fifo_dout, level.
// Macro FIFO_SCHED_CHECK_EN adds a sticky err output.
module fifo_port_sched
  import fifo_sched_pkg::*;
#(
  parameter int N_WR      = 4,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 4,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_WR-1:0]          wr_req,
  input  logic [N_WR*DW-1:0]       wr_data,
  output logic [N_WR-1:0]          wr_gnt,
  input  logic                     rd_req,
  output logic                     rd_gnt,
  output logic                     rd_valid,
  output logic [DW-1:0]            rd_data,
  output logic                     fifo_wr,
  output logic                     fifo_rd,
  output logic [DW-1:0]            fifo_din,
  input  logic                     fifo_full,
  input  logic                     fifo_empty,
  input  logic [DW-1:0]            fifo_dout,
  output logic [$clog2(DEPTH):0]   level
`ifdef FIFO_SCHED_CHECK_EN
  ,
  output logic                     err
`endif
);

  localparam int PW = $clog2(N_WR);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int LW = $clog2(DEPTH) + 1;

  state_t          state, state_n;
  side_t           side, side_n;
  logic [BW-1:0]   cnt, cnt_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic            run;

  logic [N_WR-1:0] wr_elig;
  logic            rd_elig;
  logic [N_WR-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic [N_WR-1:0] wg;
  logic            rg;
  logic            keep_wr;
  logic            keep_rd;
  logic            pick_wr;

  assign wr_elig = wr_req & {N_WR{~fifo_full}};
  assign rd_elig = rd_req & ~fifo_empty;

  rr_arbiter #(
    .N (N_WR)
  ) u_arb (
    .elig (wr_elig),
    .ptr  (ptr),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  always_comb begin
    state_n = state;
    side_n  = side;
    cnt_n   = cnt;
    ptr_n   = ptr;
    wg      = '0;
    rg      = 1'b0;
    keep_wr = (state == S_WR) && wr_elig[ptr]
              && (cnt < BW'(MAX_BURST));
    keep_rd = (state == S_RD) && rd_elig
              && (cnt < BW'(MAX_BURST));
    // Writers go first after a read burst, or when
    // the reader has nothing to do.
    pick_wr = (|wr_elig) && ((side == READ) || !rd_elig);
    // run holds off grants until the first edge after reset.
    if (run) begin
      if (keep_wr) begin
        wg[ptr] = 1'b1;
        cnt_n   = cnt + BW'(1);
      end else if (keep_rd) begin
        rg    = 1'b1;
        cnt_n = cnt + BW'(1);
      end else if (pick_wr) begin
        wg      = arb_gnt;
        ptr_n   = arb_idx;
        state_n = S_WR;
        side_n  = WRITE;
        cnt_n   = BW'(1);
      end else if (rd_elig) begin
        rg      = 1'b1;
        state_n = S_RD;
        side_n  = READ;
        cnt_n   = BW'(1);
      end else begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    end
  end

  assign wr_gnt  = wg & {N_WR{rst_n}};
  assign rd_gnt  = rg & rst_n;
  assign fifo_wr = |wr_gnt;
  assign fifo_rd = rd_gnt;
  assign rd_data = fifo_dout;

  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < N_WR; i++) begin
      if (wr_gnt[i]) fifo_din = wr_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      side     <= READ;
      cnt      <= '0;
      ptr      <= PW'(N_WR - 1);
      run      <= 1'b0;
      rd_valid <= 1'b0;
      level    <= '0;
    end else begin
      state    <= state_n;
      side     <= side_n;
      cnt      <= cnt_n;
      ptr      <= ptr_n;
      run      <= 1'b1;
      rd_valid <= rd_gnt;
      if (fifo_wr && (level != LW'(DEPTH)))
        level <= level + LW'(1);
      else if (fifo_rd && (level != '0))
        level <= level - LW'(1);
    end
  end

`ifdef FIFO_SCHED_CHECK_EN
  logic bad;

  always_comb begin
    bad = ((level == '0) != fifo_empty)
       || ((level == LW'(DEPTH)) != fifo_full)
       || (|(wr_gnt & ~wr_elig))
       || (rd_gnt & ~rd_elig);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (bad) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_port_sched.sv
// Directed bench for fifo_port_sched with a FIFO model
// and a scoreboard of expected grants and read data.
module tb_fifo_port_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] wr_req;
  logic [31:0] wr_data;
  logic [3:0] wr_gnt;
  logic       rd_req;
  logic       rd_gnt;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       fifo_wr;
  logic       fifo_rd;
  logic [7:0] fifo_din;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic [4:0] level;
`ifdef FIFO_SCHED_CHECK_EN
  logic       err;
`endif

  fifo_port_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .wr_gnt     (wr_gnt),
    .rd_req     (rd_req),
    .rd_gnt     (rd_gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .fifo_wr    (fifo_wr),
    .fifo_rd    (fifo_rd),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .level      (level)
`ifdef FIFO_SCHED_CHECK_EN
    ,
    .err        (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requesters: writer i presents base[i] + seq[i]; seq
  // advances after each grant.
  logic [7:0] base [4];
  logic [7:0] seq  [4];

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < 4; i++)
      wr_data[i*8 +: 8] = base[i] + seq[i];
  end

  // 16-deep FIFO model with registered dout.
  logic [7:0] mem [16];
  int         mcnt, mrp, mwp;
  logic       s_wr, s_rd;
  logic [7:0] s_din;
  logic [3:0] s_gnt;
  logic       force_empty;

  always @(negedge clk) begin
    s_wr  <= fifo_wr;
    s_rd  <= fifo_rd;
    s_din <= fifo_din;
    s_gnt <= wr_gnt;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt      <= 0;
      mrp       <= 0;
      mwp       <= 0;
      fifo_dout <= '0;
      for (int i = 0; i < 4; i++) seq[i] <= '0;
    end else begin
      if (s_wr && mcnt < 16) begin
        mem[mwp] <= s_din;
        mwp      <= (mwp + 1) % 16;
        mcnt     <= mcnt + 1;
      end else if (s_rd && mcnt > 0) begin
        fifo_dout <= mem[mrp];
        mrp       <= (mrp + 1) % 16;
        mcnt      <= mcnt - 1;
      end
      for (int i = 0; i < 4; i++)
        if (s_gnt[i]) seq[i] <= seq[i] + 8'd1;
    end
  end

  assign fifo_full  = (mcnt == 16);
  assign fifo_empty = force_empty | (mcnt == 0);

  typedef struct packed {
    logic [3:0] wg;
    logic       rg;
    logic [7:0] din;
    logic [4:0] lvl;
    logic       rv;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] exp_data [$];
  logic [7:0] rd_q [$];
  logic [7:0] exp_seq [4];
  int         exp_lvl;
  logic       prev_rg;
  int         total;
  int         passed;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic clear_exp();
    exp_q.delete();
    exp_data.delete();
    rd_q.delete();
    for (int i = 0; i < 4; i++) exp_seq[i] = '0;
    exp_lvl = 0;
    prev_rg = 1'b0;
  endtask

  // One cycle: push the expectation, compare at negedge,
  // then return 1 ns after the next rising edge.
  task automatic step(input logic [3:0] wg,
                      input logic rg);
    exp_t e;
    e.wg  = wg;
    e.rg  = rg;
    e.din = '0;
    e.lvl = 5'(exp_lvl);
    e.rv  = prev_rg;
    for (int i = 0; i < 4; i++) begin
      if (wg[i]) begin
        e.din      = base[i] + exp_seq[i];
        exp_seq[i] = exp_seq[i] + 8'd1;
      end
    end
    if (wg != '0) begin
      exp_data.push_back(e.din);
      if (exp_lvl < 16) exp_lvl++;
    end else if (rg) begin
      if (exp_data.size() > 0)
        rd_q.push_back(exp_data.pop_front());
      if (exp_lvl > 0) exp_lvl--;
    end
    prev_rg = rg;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("wr_gnt", 32'(wr_gnt), 32'(e.wg));
    chk("rd_gnt", 32'(rd_gnt), 32'(e.rg));
    chk("fifo_wr", 32'(fifo_wr), 32'(|e.wg));
    chk("fifo_rd", 32'(fifo_rd), 32'(e.rg));
    chk("wr_rd_excl", 32'(fifo_wr & fifo_rd), 32'd0);
    chk("fifo_din", 32'(fifo_din), 32'(e.din));
    chk("level", 32'(level), 32'(e.lvl));
    chk("rd_valid", 32'(rd_valid), 32'(e.rv));
    if (e.rv && rd_q.size() > 0)
      chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_wr_gnt", 32'(wr_gnt), 32'd0);
    chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
`ifdef FIFO_SCHED_CHECK_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_exp();
    step(4'b0000, 1'b0);
  endtask

  initial begin
    total       = 0;
    passed      = 0;
    rst_n       = 1'b1;
    wr_req      = '0;
    rd_req      = 1'b0;
    force_empty = 1'b0;
    for (int i = 0; i < 4; i++) base[i] = 8'(i * 16);
    clear_exp();
    #2;
    do_reset();

    // All four writers: 4-word bursts in rr order to full.
    wr_req = 4'b1111;
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 4; k++)
        step(4'(1 << w), 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Drain to half, then w0/w2 alternate with the reader.
    wr_req = 4'b0000;
    rd_req = 1'b1;
    for (int k = 0; k < 8; k++) step(4'b0000, 1'b1);
    wr_req = 4'b0101;
    for (int k = 0; k < 4; k++) step(4'b0001, 1'b0);
    for (int k = 0; k < 4; k++) step(4'b0000, 1'b1);
    for (int k = 0; k < 4; k++) step(4'b0100, 1'b0);
    for (int k = 0; k < 4; k++) step(4'b0000, 1'b1);
    for (int k = 0; k < 4; k++) step(4'b0001, 1'b0);

    // Full reached mid w1 burst: reader takes that cycle.
    wr_req = 4'b0000;
    for (int k = 0; k < 2; k++) step(4'b0000, 1'b1);
    rd_req = 1'b0;
    wr_req = 4'b0010;
    for (int k = 0; k < 5; k++) step(4'b0010, 1'b0);
    rd_req = 1'b1;
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b1);
    wr_req = 4'b0000;
    rd_req = 1'b0;
    step(4'b0000, 1'b0);

    // Single read of 0xA5, then a read on empty.
    do_reset();
    base[0] = 8'hA5;
    wr_req  = 4'b0001;
    step(4'b0001, 1'b0);
    wr_req = 4'b0000;
    rd_req = 1'b1;
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    rd_req = 1'b0;

    // Reset in the middle of a w1 burst.
    wr_req = 4'b1111;
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    do_reset();
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    wr_req = 4'b0000;
    step(4'b0000, 1'b0);

`ifdef FIFO_SCHED_CHECK_EN
    chk("err_clean", 32'(err), 32'd0);
    force_empty = 1'b1;
    step(4'b0000, 1'b0);
    force_empty = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    step(4'b0000, 1'b0);
    chk("err_sticky", 32'(err), 32'd1);
    do_reset();
    chk("err_cleared", 32'(err), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
